// File: rtl/focus_stm_pkg.sv
// Shared types and constants for the focus phase sequencer.
package focus_stm_pkg;

  localparam int unsigned NUM_TRANS_DEF    = 249;
  localparam int unsigned CALC_LATENCY_DEF = 40;
  localparam int unsigned IDX_W_DEF        = 8;

  localparam int unsigned FOCUS_W  = 18;
  localparam int unsigned OFFSET_W = 8;
  localparam int unsigned TRANS_W  = 16;
  localparam int unsigned PHASE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Index tag travelling alongside the calculation pipeline.
  typedef struct packed {
    logic                 valid;
    logic [IDX_W_DEF-1:0] idx;
  } tag_t;

endpackage

// File: rtl/focus_stm_sequencer_tag_delay.sv
// Fixed-depth shift register of index tags; reports whether any tag is in flight.
module tag_delay
  import focus_stm_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t push_tag,
  output tag_t aligned_tag,
  output logic any_valid
);

  tag_t stages [DEPTH];

  // Shift one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign aligned_tag = stages[DEPTH-1];

  // OR of all stage valid bits, used to decide when draining is complete.
  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stages[i].valid;
    end
  end

endmodule

// File: rtl/focus_stm_sequencer.sv
// Sequences one focus point through the phase pipeline: walks the position ROM,
// tags each index, and re-aligns the tags with the pipeline's SIN/COS results.
module focus_stm_sequencer
  import focus_stm_pkg::*;
#(
  parameter int unsigned NUM_TRANS    = NUM_TRANS_DEF,
  parameter int unsigned IDX_W        = IDX_W_DEF,
  parameter int unsigned CALC_LATENCY = CALC_LATENCY_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic signed [FOCUS_W-1:0]  focus_x,
  input  logic signed [FOCUS_W-1:0]  focus_y,
  input  logic signed [FOCUS_W-1:0]  focus_z,
  input  logic        [OFFSET_W-1:0] offset,
  output logic                       busy,
  output logic                       done,
  output logic        [IDX_W-1:0]    tr_addr,
  input  logic        [TRANS_W-1:0]  tr_x,
  input  logic        [TRANS_W-1:0]  tr_y,
  output logic signed [FOCUS_W-1:0]  calc_focus_x,
  output logic signed [FOCUS_W-1:0]  calc_focus_y,
  output logic signed [FOCUS_W-1:0]  calc_focus_z,
  output logic        [OFFSET_W-1:0] calc_offset,
  output logic        [TRANS_W-1:0]  calc_trans_x,
  output logic        [TRANS_W-1:0]  calc_trans_y,
  input  logic        [PHASE_W-1:0]  calc_sin,
  input  logic        [PHASE_W-1:0]  calc_cos,
  output logic                       out_valid,
  output logic        [IDX_W-1:0]    out_idx,
  output logic        [PHASE_W-1:0]  out_sin,
  output logic        [PHASE_W-1:0]  out_cos
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TRANS - 1);

  state_e                     state, state_d;
  logic        [IDX_W-1:0]    tr_addr_d;
  logic                       busy_d, done_d;
  logic signed [FOCUS_W-1:0]  focus_x_d, focus_y_d, focus_z_d;
  logic        [OFFSET_W-1:0] offset_d;

  tag_t issue_tag, aligned_tag;
  logic tags_in_flight;

  // Next-state and next-output logic for the issue/drain sequence.
  always_comb begin
    state_d   = state;
    tr_addr_d = tr_addr;
    busy_d    = busy;
    done_d    = 1'b0;
    focus_x_d = calc_focus_x;
    focus_y_d = calc_focus_y;
    focus_z_d = calc_focus_z;
    offset_d  = calc_offset;
    case (state)
      IDLE: begin
        if (start) begin
          state_d   = ISSUE;
          tr_addr_d = '0;
          busy_d    = 1'b1;
          focus_x_d = focus_x;
          focus_y_d = focus_y;
          focus_z_d = focus_z;
          offset_d  = offset;
        end
      end
      ISSUE: begin
        if (tr_addr == LAST_IDX) begin
          state_d = DRAIN;
        end else begin
          tr_addr_d = tr_addr + IDX_W'(1);
        end
      end
      DRAIN: begin
        // DONE is held for one cycle in DRAIN so START stays ignored during it.
        if (done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!tags_in_flight) begin
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Control outputs and the focus/offset latched for the whole run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tr_addr      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      calc_focus_x <= '0;
      calc_focus_y <= '0;
      calc_focus_z <= '0;
      calc_offset  <= '0;
    end else begin
      tr_addr      <= tr_addr_d;
      busy         <= busy_d;
      done         <= done_d;
      calc_focus_x <= focus_x_d;
      calc_focus_y <= focus_y_d;
      calc_focus_z <= focus_z_d;
      calc_offset  <= offset_d;
    end
  end

  assign calc_trans_x = tr_x;
  assign calc_trans_y = tr_y;

  assign issue_tag.valid = (state == ISSUE);
  assign issue_tag.idx   = IDX_W_DEF'(tr_addr);

  // One extra stage covers the ROM read cycle ahead of the pipeline.
  tag_delay #(
    .DEPTH(CALC_LATENCY + 1)
  ) u_tag_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_tag   (issue_tag),
    .aligned_tag(aligned_tag),
    .any_valid  (tags_in_flight)
  );

  // Register the indexed result; payload holds while no result is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_sin   <= '0;
      out_cos   <= '0;
    end else begin
      out_valid <= aligned_tag.valid;
      if (aligned_tag.valid) begin
        out_idx <= IDX_W'(aligned_tag.idx);
        out_sin <= calc_sin;
        out_cos <= calc_cos;
      end
    end
  end

endmodule

// File: tb/tb_focus_stm_sequencer.sv
// Scoreboard bench for focus_stm_sequencer: a nominal-size instance and a
// single-transducer, short-latency instance share clock, reset and focus inputs.
`timescale 1ns/1ps
module tb_focus_stm_sequencer;

  localparam int A_N = 249;
  localparam int A_L = 40;
  localparam int B_N = 1;
  localparam int B_L = 3;

  typedef struct {
    int         cyc;
    logic [7:0] idx;
    logic [7:0] s;
    logic [7:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_start, b_start;
  logic signed [17:0] focus_x, focus_y, focus_z;
  logic [7:0] offset;

  logic a_busy, a_done, a_out_valid;
  logic [7:0] a_tr_addr, a_out_idx, a_out_sin, a_out_cos, a_calc_offset;
  logic [15:0] a_rom_x, a_rom_y, a_calc_trans_x, a_calc_trans_y;
  logic signed [17:0] a_calc_focus_x, a_calc_focus_y, a_calc_focus_z;
  logic [7:0] a_ps [A_L];
  logic [7:0] a_pc [A_L];

  logic b_busy, b_done, b_out_valid;
  logic [7:0] b_tr_addr, b_out_idx, b_out_sin, b_out_cos, b_calc_offset;
  logic [15:0] b_rom_x, b_rom_y, b_calc_trans_x, b_calc_trans_y;
  logic signed [17:0] b_calc_focus_x, b_calc_focus_y, b_calc_focus_z;
  logic [7:0] b_ps [B_L];
  logic [7:0] b_pc [B_L];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit jitter = 1'b0;

  exp_t qa[$];
  exp_t qb[$];
  int   qa_done[$];
  int   qb_done[$];
  exp_t ea, eb;
  int a_s = 0, a_lo = 0, a_hi = -1, b_lo = 0, b_hi = -1;
  logic [7:0] a_hold_idx = '0, a_hold_sin = '0, a_hold_cos = '0;
  logic signed [17:0] exp_fx = '0, exp_fy = '0, exp_fz = '0;
  logic [7:0] exp_off = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM models (1-cycle read) and fixed-latency calc models
  always @(posedge clk) begin
    a_rom_x <= 16'(int'(a_tr_addr) * 10);
    a_rom_y <= 16'(int'(a_tr_addr) * 20);
    b_rom_x <= 16'(int'(b_tr_addr) + 'h55);
    b_rom_y <= 16'(int'(b_tr_addr) + 'hA3);
    a_ps[0] <= a_calc_trans_x[7:0];
    a_pc[0] <= a_calc_trans_y[7:0];
    for (int k = 1; k < A_L; k++) begin
      a_ps[k] <= a_ps[k-1];
      a_pc[k] <= a_pc[k-1];
    end
    b_ps[0] <= b_calc_trans_x[7:0];
    b_pc[0] <= b_calc_trans_y[7:0];
    for (int k = 1; k < B_L; k++) begin
      b_ps[k] <= b_ps[k-1];
      b_pc[k] <= b_pc[k-1];
    end
  end

  focus_stm_sequencer #(.NUM_TRANS(A_N), .IDX_W(8), .CALC_LATENCY(A_L)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start),
    .focus_x(focus_x), .focus_y(focus_y), .focus_z(focus_z), .offset(offset),
    .busy(a_busy), .done(a_done), .tr_addr(a_tr_addr), .tr_x(a_rom_x), .tr_y(a_rom_y),
    .calc_focus_x(a_calc_focus_x), .calc_focus_y(a_calc_focus_y), .calc_focus_z(a_calc_focus_z),
    .calc_offset(a_calc_offset), .calc_trans_x(a_calc_trans_x), .calc_trans_y(a_calc_trans_y),
    .calc_sin(a_ps[A_L-1]), .calc_cos(a_pc[A_L-1]),
    .out_valid(a_out_valid), .out_idx(a_out_idx), .out_sin(a_out_sin), .out_cos(a_out_cos)
  );

  focus_stm_sequencer #(.NUM_TRANS(B_N), .IDX_W(8), .CALC_LATENCY(B_L)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start),
    .focus_x(focus_x), .focus_y(focus_y), .focus_z(focus_z), .offset(offset),
    .busy(b_busy), .done(b_done), .tr_addr(b_tr_addr), .tr_x(b_rom_x), .tr_y(b_rom_y),
    .calc_focus_x(b_calc_focus_x), .calc_focus_y(b_calc_focus_y), .calc_focus_z(b_calc_focus_z),
    .calc_offset(b_calc_offset), .calc_trans_x(b_calc_trans_x), .calc_trans_y(b_calc_trans_y),
    .calc_sin(b_ps[B_L-1]), .calc_cos(b_pc[B_L-1]),
    .out_valid(b_out_valid), .out_idx(b_out_idx), .out_sin(b_out_sin), .out_cos(b_out_cos)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (jitter) begin
      focus_x = 18'($urandom);
      focus_y = 18'($urandom);
      focus_z = 18'($urandom);
      offset  = 8'($urandom);
    end
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic start_a(input logic signed [17:0] fx, input logic signed [17:0] fy,
                         input logic signed [17:0] fz, input logic [7:0] off, input bit accept);
    exp_t e;
    a_start = 1'b1;
    focus_x = fx; focus_y = fy; focus_z = fz; offset = off;
    if (accept) begin
      a_s = cyc;
      for (int i = 0; i < A_N; i++) begin
        e.cyc = cyc + 3 + A_L + i;
        e.idx = 8'(i);
        e.s   = 8'(i * 10);
        e.c   = 8'(i * 20);
        qa.push_back(e);
      end
      qa_done.push_back(cyc + 3 + A_L + A_N);
      a_lo = cyc + 1;
      a_hi = cyc + 3 + A_L + A_N;
      exp_fx = fx; exp_fy = fy; exp_fz = fz; exp_off = off;
    end
    tick();
    a_start = 1'b0;
  endtask

  task automatic start_b();
    exp_t e;
    b_start = 1'b1;
    for (int i = 0; i < B_N; i++) begin
      e.cyc = cyc + 3 + B_L + i;
      e.idx = 8'(i);
      e.s   = 8'(i + 'h55);
      e.c   = 8'(i + 'hA3);
      qb.push_back(e);
    end
    qb_done.push_back(cyc + 3 + B_L + B_N);
    b_lo = cyc + 1;
    b_hi = cyc + 3 + B_L + B_N;
    tick();
    b_start = 1'b0;
  endtask

  // Monitor for the nominal instance
  always @(negedge clk) begin
    if (a_out_valid) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid: got idx %0d expected no result (cycle %0d)", a_out_idx, cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_out_cycle", cyc, ea.cyc);
        chk("a_out_idx", a_out_idx, ea.idx);
        chk("a_out_sin", a_out_sin, ea.s);
        chk("a_out_cos", a_out_cos, ea.c);
        a_hold_idx = ea.idx; a_hold_sin = ea.s; a_hold_cos = ea.c;
      end
    end else begin
      chk("a_hold_idx", a_out_idx, a_hold_idx);
      chk("a_hold_sin", a_out_sin, a_hold_sin);
      chk("a_hold_cos", a_out_cos, a_hold_cos);
    end
    if (a_done) begin
      if (qa_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_done: got done expected none (cycle %0d)", cyc);
      end else begin
        chk("a_done_cycle", cyc, qa_done.pop_front());
      end
    end
    chk("a_busy", a_busy, (cyc >= a_lo && cyc <= a_hi) ? 1 : 0);
    if (cyc >= a_lo && cyc <= a_hi) begin
      chk("a_calc_focus_x", a_calc_focus_x, exp_fx);
      chk("a_calc_focus_y", a_calc_focus_y, exp_fy);
      chk("a_calc_focus_z", a_calc_focus_z, exp_fz);
      chk("a_calc_offset", a_calc_offset, exp_off);
    end
  end

  // Monitor for the single-transducer instance
  always @(negedge clk) begin
    if (b_out_valid) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid: got idx %0d expected no result (cycle %0d)", b_out_idx, cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_out_cycle", cyc, eb.cyc);
        chk("b_out_idx", b_out_idx, eb.idx);
        chk("b_out_sin", b_out_sin, eb.s);
        chk("b_out_cos", b_out_cos, eb.c);
      end
    end
    if (b_done) begin
      if (qb_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_done: got done expected none (cycle %0d)", cyc);
      end else begin
        chk("b_done_cycle", cyc, qb_done.pop_front());
      end
    end
    chk("b_busy", b_busy, (cyc >= b_lo && cyc <= b_hi) ? 1 : 0);
  end

  task automatic chk_a_zero(input string tag);
    chk({tag, "_out_valid"}, a_out_valid, 0);
    chk({tag, "_out_idx"}, a_out_idx, 0);
    chk({tag, "_out_sin"}, a_out_sin, 0);
    chk({tag, "_busy"}, a_busy, 0);
    chk({tag, "_done"}, a_done, 0);
    chk({tag, "_tr_addr"}, a_tr_addr, 0);
    chk({tag, "_calc_focus_x"}, a_calc_focus_x, 0);
    chk({tag, "_calc_offset"}, a_calc_offset, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    focus_x = '0; focus_y = '0; focus_z = '0; offset = '0;
    repeat (3) tick();
    chk_a_zero("rst_a");
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_busy", b_busy, 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single transducer, latency 3: result at start+6, DONE at start+7
    focus_x = 18'sd11; focus_y = 18'sd22; focus_z = 18'sd33; offset = 8'h44;
    start_b();
    repeat (12) tick();
    chk("b_tr_addr_hold", b_tr_addr, 0);

    // Nominal run with jittering focus inputs and ignored STARTs
    start_a(18'sd1000, 18'sd2000, 18'sd3000, 8'h10, 1'b1);
    jitter = 1'b1;
    tick_to(a_s + 5);
    start_a(-18'sd1, -18'sd2, -18'sd3, 8'hEE, 1'b0);
    tick_to(a_s + 200);
    start_a(18'sd500, 18'sd600, 18'sd700, 8'h77, 1'b0);
    tick_to(a_s + 3 + A_L + A_N);
    chk("a_tr_addr_hold", a_tr_addr, A_N - 1);
    chk("a_done_now", a_done, 1);
    start_a(18'sd7, 18'sd8, 18'sd9, 8'h33, 1'b0);

    // Restart one cycle after DONE
    start_a(-18'sd5, -18'sd6, -18'sd7, 8'h22, 1'b1);
    chk("a_restart_addr0", a_tr_addr, 0);
    tick();
    chk("a_restart_addr1", a_tr_addr, 1);

    // Reset in mid-run: everything clears, no results or DONE afterwards
    tick_to(a_s + 100);
    #2;
    rst_n = 1'b0;
    qa.delete();
    qa_done.delete();
    a_hi = -1;
    a_hold_idx = '0; a_hold_sin = '0; a_hold_cos = '0;
    #1;
    chk_a_zero("midrst_a");
    tick();
    tick();
    rst_n = 1'b1;
    repeat (60) tick();

    // Clean full run after reset
    start_a(18'sd12345, -18'sd12345, 18'sd131071, 8'hFF, 1'b1);
    tick_to(a_s + 300);
    jitter = 1'b0;

    chk("a_results_left", qa.size(), 0);
    chk("a_done_left", qa_done.size(), 0);
    chk("b_results_left", qb.size(), 0);
    chk("b_done_left", qb_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
